// File: rtl/seq_pattern_matcher.sv
// seq_pattern_matcher: serial bit-pattern detector with a runtime-programmable
// pattern of 1..PAT_W bits, overlapping/non-overlapping match modes and a
// saturating match counter.
// Optional feature macro: SEQ_LOCKOUT_EN -- when defined, the block enters a
// sticky LOCK state once match_cnt reaches MAX_MATCH (MAX_MATCH=0 disables it).
module seq_pattern_matcher #(
  parameter int PAT_W     = 8,
  parameter int LEN_W     = $clog2(PAT_W + 1),
  parameter int CNT_W     = 8,
  parameter int MAX_MATCH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [LEN_W-1:0] pat_len,
  input  logic             ovl,
  input  logic             in_valid,
  input  logic             in,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             armed,
  output logic             locked
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LOCK = 2'd2
  } state_e;

`ifdef SEQ_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  localparam logic [LEN_W-1:0] LEN_ONE     = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_MAX     = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] LEN_ZERO    = {LEN_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_SAT     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] MAX_MATCH_C = CNT_W'(MAX_MATCH);
  localparam logic [PAT_W-1:0] PAT_ZERO    = {PAT_W{1'b0}};
  localparam logic [PAT_W-1:0] PAT_ONE     = PAT_W'(1);
  // A threshold the saturating counter can never hold would never lock.
  localparam bit LOCK_REACHABLE = (MAX_MATCH > 0) && ((MAX_MATCH >> CNT_W) == 0);

  // Out-of-range lengths are clamped into 1..PAT_W.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    logic [LEN_W-1:0] res;
    if (len == LEN_ZERO) begin
      res = LEN_ONE;
    end else if (len > LEN_MAX) begin
      res = LEN_MAX;
    end else begin
      res = len;
    end
    return res;
  endfunction

  // Mask selecting the low len bits of the history/pattern.
  function automatic logic [PAT_W-1:0] len_mask(input logic [LEN_W-1:0] len);
    logic [PAT_W-1:0] m;
    for (int i = 0; i < PAT_W; i++) begin
      m[i] = (i < int'(len));
    end
    return m;
  endfunction

  state_e           state_q, state_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             match_q, match_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [PAT_W-1:0] hist_shift_s;
  logic [LEN_W-1:0] fill_inc_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             hit_s;
  logic             lock_hit_s;
  logic             armed_s;
  logic             locked_s;

  // Hit detection on the post-shift history of an accepted beat.
  always_comb begin
    hist_shift_s = (hist_q << 1) | (in ? PAT_ONE : PAT_ZERO);
    if (fill_q >= LEN_MAX) begin
      fill_inc_s = fill_q;
    end else begin
      fill_inc_s = fill_q + LEN_ONE;
    end
    if (cnt_q == CNT_SAT) begin
      cnt_inc_s = cnt_q;
    end else begin
      cnt_inc_s = cnt_q + CNT_ONE;
    end
    hit_s = (state_q == S_RUN) && !pat_load && in_valid &&
            (fill_inc_s >= len_q) &&
            (((hist_shift_s ^ pat_q) & len_mask(len_q)) == PAT_ZERO);
    lock_hit_s = LOCK_EN && LOCK_REACHABLE && hit_s && (cnt_inc_s == MAX_MATCH_C);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; LOCK is left only through rst.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (pat_load) begin
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (pat_load) begin
          state_d = S_RUN;
        end else if (lock_hit_s) begin
          state_d = S_LOCK;
        end else begin
          state_d = S_RUN;
        end
      end
      S_LOCK: begin
        if (LOCK_EN) begin
          state_d = S_LOCK;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: load, shift, match pulse and saturating count.
  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    match_d = 1'b0;
    case (state_q)
      S_IDLE, S_RUN: begin
        if (pat_load) begin
          pat_d  = pat_in;
          len_d  = clamp_len(pat_len);
          hist_d = PAT_ZERO;
          fill_d = LEN_ZERO;
          cnt_d  = CNT_ZERO;
        end else if (state_q == S_RUN && in_valid) begin
          if (hit_s) begin
            match_d = 1'b1;
            cnt_d   = cnt_inc_s;
            if (ovl) begin
              hist_d = hist_shift_s;
              fill_d = fill_inc_s;
            end else begin
              hist_d = PAT_ZERO;
              fill_d = LEN_ZERO;
            end
          end else begin
            hist_d = hist_shift_s;
            fill_d = fill_inc_s;
          end
        end else begin
          hist_d = hist_q;
        end
      end
      default: begin
        hist_d = hist_q;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q  <= PAT_ZERO;
      fill_q  <= LEN_ZERO;
      pat_q   <= PAT_ZERO;
      len_q   <= LEN_ONE;
      cnt_q   <= CNT_ZERO;
      match_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
    end
  end

  // Status outputs decoded from the state register.
  always_comb begin
    armed_s = (state_q == S_RUN);
`ifdef SEQ_LOCKOUT_EN
    locked_s = (state_q == S_LOCK);
`else
    locked_s = 1'b0;
`endif
  end

  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign armed     = armed_s;
  assign locked    = locked_s;

endmodule

// File: tb/tb_seq_pattern_matcher.sv
// Testbench for seq_pattern_matcher: directed scenarios plus randomized
// traffic checked against a queue-based reference model.
module tb_seq_pattern_matcher;

  localparam int MAXM = 2;
`ifdef SEQ_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       pat_load;
  logic [7:0] pat_in;
  logic [3:0] pat_len;
  logic       ovl;
  logic       in_valid;
  logic       in_b;
  logic       match;
  logic [7:0] match_cnt;
  logic       armed;
  logic       locked;
  logic       match_sat;
  logic [1:0] cnt_sat;
  logic       armed_sat;
  logic       locked_sat;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit         m_armed;
  bit         m_locked;
  bit         m_match;
  int         m_count;
  bit         m_q[$];
  logic [7:0] m_pat;
  int         m_len;

  seq_pattern_matcher #(.PAT_W(8), .CNT_W(8), .MAX_MATCH(MAXM)) dut (
    .clk(clk), .rst(rst), .pat_load(pat_load), .pat_in(pat_in), .pat_len(pat_len),
    .ovl(ovl), .in_valid(in_valid), .in(in_b), .match(match), .match_cnt(match_cnt),
    .armed(armed), .locked(locked));

  seq_pattern_matcher #(.PAT_W(8), .CNT_W(2), .MAX_MATCH(0)) dut_sat (
    .clk(clk), .rst(rst), .pat_load(pat_load), .pat_in(pat_in), .pat_len(pat_len),
    .ovl(ovl), .in_valid(in_valid), .in(in_b), .match(match_sat), .match_cnt(cnt_sat),
    .armed(armed_sat), .locked(locked_sat));

  always #5 clk = ~clk;

  function automatic logic [7:0] m_cnt();
    return (m_count > 255) ? 8'd255 : m_count[7:0];
  endfunction

  function automatic logic [10:0] exp_vec();
    return {m_match, m_cnt(), m_armed, m_locked};
  endfunction

  function automatic logic [10:0] obs_vec();
    return {match, match_cnt, armed, locked};
  endfunction

  function automatic void model_reset();
    m_armed = 1'b0; m_locked = 1'b0; m_match = 1'b0; m_count = 0;
    m_q.delete(); m_pat = 8'h00; m_len = 1;
  endfunction

  // One sampled beat of the specified behaviour.
  function automatic void model_step(input bit ld, input int len, input logic [7:0] pat,
                                     input bit v, input bit b, input bit o);
    bit hit;
    m_match = 1'b0;
    if (m_locked) return;
    if (ld) begin
      m_armed = 1'b1;
      m_pat   = pat;
      m_len   = (len < 1) ? 1 : ((len > 8) ? 8 : len);
      m_q.delete();
      m_count = 0;
    end else if (m_armed && v) begin
      m_q.push_back(b);
      if (m_q.size() > 8) void'(m_q.pop_front());
      hit = (m_q.size() >= m_len);
      if (hit) begin
        for (int i = 0; i < m_len; i++) begin
          if (m_q[m_q.size() - 1 - i] != m_pat[i]) hit = 1'b0;
        end
      end
      if (hit) begin
        m_match = 1'b1;
        m_count++;
        if (!o) m_q.delete();
        if (LOCK_EN && MAXM != 0 && m_cnt() == 8'(MAXM)) begin
          m_locked = 1'b1;
          m_armed  = 1'b0;
        end
      end
    end
  endfunction

  task automatic cycle(input bit ld, input logic [3:0] len, input logic [7:0] pat,
                       input bit v, input bit b, input bit o);
    pat_load = ld; pat_len = len; pat_in = pat; in_valid = v; in_b = b; ovl = o;
    @(posedge clk);
    #1;
    model_step(ld, int'(len), pat, v, b, o);
    pat_load = 1'b0; in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (obs_vec() !== 11'd0) begin
      errors++; $display("FAIL reset_outputs: got %h expected %h", obs_vec(), 11'd0);
    end
    #2; rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 4'd1, 8'h01, 1'b1, 1'b1, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec() || armed !== 1'b0 || match !== 1'b0) begin
        errors++; $display("FAIL idle_ignore: got %h expected %h", obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_exact();
    bit s[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    cycle(1'b1, 4'd4, 8'h0B, 1'b0, 1'b0, 1'b0);
    checks++;
    if (armed !== 1'b1 || obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL exact_load: got %h expected %h", obs_vec(), exp_vec());
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 4'd4, 8'h0B, 1'b1, s[i], 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL exact_beat%0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (match !== 1'b1 || match_cnt !== 8'd1) begin
      errors++; $display("FAIL exact_hit: got match=%b cnt=%0d expected match=1 cnt=1", match, match_cnt);
    end
    cycle(1'b0, 4'd4, 8'h0B, 1'b0, 1'b0, 1'b0);
    checks++;
    if (match !== 1'b0 || match_cnt !== 8'd1) begin
      errors++; $display("FAIL exact_pulse_width: got match=%b cnt=%0d expected match=0 cnt=1", match, match_cnt);
    end
  endtask

  task automatic test_overlap();
    bit s[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int pulses;
    for (int o = 0; o < 2; o++) begin
      do_reset();
      cycle(1'b1, 4'd3, 8'h05, 1'b0, 1'b0, o[0]);
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
        cycle(1'b0, 4'd3, 8'h05, 1'b1, s[i], o[0]);
        pulses += int'(match);
        checks++;
        if (obs_vec() !== exp_vec()) begin
          errors++; $display("FAIL overlap%0d_beat%0d: got %h expected %h", o, i, obs_vec(), exp_vec());
        end
      end
      checks++;
      if (pulses != (o == 1 ? 2 : 1) || match_cnt !== (o == 1 ? 8'd2 : 8'd1)) begin
        errors++; $display("FAIL overlap%0d_count: got pulses=%0d cnt=%0d expected %0d", o, pulses, match_cnt, (o == 1 ? 2 : 1));
      end
    end
  endtask

  task automatic test_gaps();
    bit s[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int pulses = 0;
    do_reset();
    cycle(1'b1, 4'd4, 8'h0B, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 4'd4, 8'h0B, 1'b1, s[i], 1'b0);
      pulses += int'(match);
      for (int g = 0; g < 2; g++) begin
        cycle(1'b0, 4'd4, 8'h0B, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        pulses += int'(match);
        checks++;
        if (obs_vec() !== exp_vec()) begin
          errors++; $display("FAIL gap_%0d_%0d: got %h expected %h", i, g, obs_vec(), exp_vec());
        end
      end
    end
    checks++;
    if (pulses != 1 || match_cnt !== 8'd1) begin
      errors++; $display("FAIL gaps_count: got pulses=%0d cnt=%0d expected 1", pulses, match_cnt);
    end
  endtask

  task automatic test_clamp();
    bit s[3] = '{1'b1, 1'b1, 1'b0};
    logic [7:0] a5 = 8'hA5;
    logic [2:0] seq;
    int pulses = 0;
    do_reset();
    cycle(1'b1, 4'd0, 8'h01, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 4'd0, 8'h01, 1'b1, s[i], 1'b0);
      seq[i] = match;
    end
    checks++;
    if (seq !== 3'b011) begin
      errors++; $display("FAIL clamp_len0: got %b expected %b", seq, 3'b011);
    end
    cycle(1'b1, 4'd15, 8'hA5, 1'b0, 1'b0, 1'b1);
    for (int i = 7; i >= 0; i--) begin
      cycle(1'b0, 4'd15, 8'hA5, 1'b1, a5[i], 1'b1);
      pulses += int'(match);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL clamp_max_bit%0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (pulses != 1 || match !== 1'b1) begin
      errors++; $display("FAIL clamp_max: got pulses=%0d last=%b expected 1", pulses, match);
    end
  endtask

  task automatic test_saturation();
    int pulses = 0;
    int want;
    do_reset();
    cycle(1'b1, 4'd1, 8'h01, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 4'd1, 8'h01, 1'b1, 1'b1, 1'b0);
      want = (i + 1 > 3) ? 3 : i + 1;
      pulses += int'(match_sat);
      checks++;
      if (match_sat !== 1'b1 || cnt_sat !== 2'(want)) begin
        errors++; $display("FAIL sat_beat%0d: got match=%b cnt=%0d expected 1/%0d", i, match_sat, cnt_sat, want);
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL sat_main%0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (pulses != 8 || cnt_sat !== 2'd3 || armed_sat !== 1'b1 || locked_sat !== 1'b0) begin
      errors++; $display("FAIL sat_final: got pulses=%0d cnt=%0d armed=%b locked=%b expected 8/3/1/0", pulses, cnt_sat, armed_sat, locked_sat);
    end
  endtask

  task automatic test_lockout();
    logic [3:0] seq;
    do_reset();
    cycle(1'b1, 4'd2, 8'h03, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 4'd2, 8'h03, 1'b1, 1'b1, 1'b1);
      seq[i] = match;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL lock_beat%0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
`ifdef SEQ_LOCKOUT_EN
    checks++;
    if (seq !== 4'b0110 || match_cnt !== 8'd2 || locked !== 1'b1 || armed !== 1'b0) begin
      errors++; $display("FAIL lock_enter: got seq=%b cnt=%0d locked=%b expected 0110/2/1", seq, match_cnt, locked);
    end
    cycle(1'b1, 4'd1, 8'hFF, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 4'd1, 8'hFF, 1'b1, 1'b1, 1'b1);
      checks++;
      if (obs_vec() !== exp_vec() || match !== 1'b0 || match_cnt !== 8'd2 || locked !== 1'b1) begin
        errors++; $display("FAIL lock_hold%0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    #2; rst = 1'b1; #1;
    checks++;
    if (obs_vec() !== 11'd0) begin
      errors++; $display("FAIL lock_rst: got %h expected %h", obs_vec(), 11'd0);
    end
    model_reset();
    rst = 1'b0;
`else
    checks++;
    if (seq !== 4'b1110 || match_cnt !== 8'd3 || locked !== 1'b0) begin
      errors++; $display("FAIL nolock_run: got seq=%b cnt=%0d locked=%b expected 1110/3/0", seq, match_cnt, locked);
    end
`endif
  endtask

  task automatic test_reset_mid();
    bit s[3] = '{1'b1, 1'b0, 1'b1};
    do_reset();
    cycle(1'b1, 4'd4, 8'h0B, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'd4, 8'h0B, 1'b1, s[i], 1'b0);
    checks++;
    if (armed !== 1'b1) begin
      errors++; $display("FAIL mid_armed: got %b expected 1", armed);
    end
    #3; rst = 1'b1; #1;
    checks++;
    if (obs_vec() !== 11'd0) begin
      errors++; $display("FAIL mid_async_rst: got %h expected %h", obs_vec(), 11'd0);
    end
    model_reset();
    #1; rst = 1'b0;
    cycle(1'b1, 4'd4, 8'h0B, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 4'd4, 8'h0B, 1'b1, 1'b1, 1'b0);
    checks++;
    if (match !== 1'b0 || obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL mid_no_match: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    bit ld;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      if (m_locked && $urandom_range(0, 9) == 0) do_reset();
      ld = (n == 0) || ($urandom_range(0, 39) == 0);
      cycle(ld, 4'($urandom_range(0, 15)), 8'($urandom), ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL random_%0d: got %h expected %h", n, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    rst = 1'b1; pat_load = 1'b0; pat_in = 8'h00; pat_len = 4'd0;
    ovl = 1'b0; in_valid = 1'b0; in_b = 1'b0;
    model_reset();
    #1;
    test_reset();
    test_exact();
    test_overlap();
    test_gaps();
    test_clamp();
    test_saturation();
    test_lockout();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_pattern_matcher.md
# seq_pattern_matcher

Parametrised serial bit-pattern detector. It matches a runtime-programmable pattern of 1..PAT_W bits against a qualified serial input stream. It supports overlapping and non-overlapping match modes and keeps a saturating match counter. When compiled with the lockout feature, it enters a sticky lock after a configurable number of matches. It sits in the lab datapath in place of the fixed-pattern serial detectors, fed by the same serial source.

## Interface
- PAT_W, 8, maximum pattern length in bits (≥2)
- LEN_W, $clog2(PAT_W+1), width of the pattern-length field
- CNT_W, 8, match counter width
- MAX_MATCH, 3, number of matches that triggers lock; used only with SEQ_LOCKOUT_EN
- clk  in  1  clock; all logic is rising-edge
- rst  in  1  reset; asynchronous, active-high
- pat_load  in  1  load pattern/length; clears history and counter
- pat_in  in  PAT_W  pattern; bit [len-1] is the first-received bit, bit [0] is the last-received bit
- pat_len  in  LEN_W  pattern length; values are clamped to the range 1..PAT_W
- ovl  in  1  1 = overlapping matches, 0 = non-overlapping; sampled on each valid beat
- in_valid  in  1  serial bit qualifier
- in  in  1  serial data bit
- match  out  1  one-cycle registered match pulse
- match_cnt  out  CNT_W  saturating count of matches since load/reset
- armed  out  1  a pattern is loaded and the block is accepting bits
- locked  out  1  sticky lockout flag

## Operation
- States:
  - IDLE: no pattern loaded. Bits are ignored.
  - RUN: matching.
  - LOCK: sticky; only present with SEQ_LOCKOUT_EN.
- Reset (async): state=IDLE. Registers cleared: history, fill, pattern, length=1. Outputs: match=0, match_cnt=0, armed=0, locked=0.
- pat_load=1 in IDLE or RUN:
  - Captures pat_in and clamped pat_len (0→1, >PAT_W→PAT_W).
  - Clears history, fill and match_cnt; forces match=0.
  - Next state is RUN.
  - pat_load takes priority over a same-cycle in_valid; that bit is discarded.
- pat_load in LOCK: ignored.
- History is a PAT_W-bit shift register. On each valid beat in RUN, the new bit shifts into bit [0].
- fill counts accepted bits since load or since the last non-overlapping match, saturating at PAT_W.
- A beat is a hit when both hold:
  - fill-after-shift ≥ len
  - the low len bits of the post-shift history equal the low len bits of the pattern.
- On a hit:
  - match is asserted next cycle.
  - match_cnt increments, saturating at 2^CNT_W−1; it never wraps.
  - If ovl=0, history and fill clear to 0, so the next match needs len fresh bits.
  - If ovl=1, history is retained.
- in_valid=0: no shift, no hit, history held.
- armed=1 exactly in RUN.

## Timing
- Latency: match rises on the clock edge after the edge that samples the completing bit. It is high for exactly one cycle per hit.
- Back-to-back hits on consecutive valid beats (e.g. len=1, or overlapping patterns) produce match high on consecutive cycles.
- match_cnt updates on the same edge that match rises.
- pat_load takes effect on the sampling edge; armed=1 from the next cycle. The first bit can be accepted on the cycle after the load.
- rst asserted mid-stream clears all outputs immediately (asynchronously), without waiting for a clock.

## Configuration
- SEQ_LOCKOUT_EN defined:
  - On the edge where match_cnt reaches MAX_MATCH, state becomes LOCK and locked=1 in the same cycle match pulses.
  - In LOCK: in_valid and pat_load are ignored, match stays 0, and match_cnt is frozen.
  - Only rst exits LOCK.
  - MAX_MATCH=0 disables locking.
- SEQ_LOCKOUT_EN undefined:
  - No LOCK state; locked is tied to 0.
  - MAX_MATCH is unused; matching continues indefinitely.

## Test plan
- Exact match: PAT_W=8; load pat_in=8'h0B, pat_len=4 (pattern 1011). Feed 1,0,1,1 on consecutive valid beats → one match pulse the cycle after the 4th bit; match_cnt=1.
- Overlap vs non-overlap: pattern 101, len=3; stream 1,0,1,0,1.
  - ovl=1 → 2 pulses (after bits 3 and 5), match_cnt=2.
  - ovl=0 → 1 pulse, match_cnt=1.
- Gaps and clamping:
  - Stream 1011 with in_valid=0 cycles inserted between bits → still exactly 1 match.
  - pat_len=0 with pat_in[0]=1 → len clamps to 1; stream 1,1,0 → match on 2 consecutive cycles.
- Saturation: CNT_W=2, len=1, pattern 1; eight consecutive 1 bits, lockout undefined → match_cnt stops at 3 and does not wrap; match still pulses 8 times.
- Lockout (SEQ_LOCKOUT_EN, MAX_MATCH=2), pattern 11, ovl=1: stream 1,1,1,1 → locked=1 with the 2nd pulse and match_cnt=2. A further pat_load and more bits → no change. rst → all outputs 0.
- Reset mid-operation: assert rst asynchronously after 3 of 4 pattern bits → outputs 0 immediately. After reload, the 4th bit alone → no match.
